rgmii_rx_frame_parser: RTL and testbench
========================================

Name: rgmii_rx_frame_parser

Overview:
Upstream neighbour of the RGMII receive buffer, in the i_rxc domain. Takes RGMII receive data already converted to single-data-rate by the IDDR stage. Decodes in-band link/speed status and assembles nibbles into bytes at 10/100. Strips preamble/SFD and drives the buffer's byte-write interface (data, valid, end pulse, speed flag).

Parameters:
MAX_LEN, 1526, maximum post-SFD bytes forwarded per frame; the buffer RAM depth.
PRE_MAX, 8, maximum bytes (including SFD) allowed from DV rise to SFD.
LEN_W, 11, width of the internal byte counter; must satisfy 2^LEN_W > MAX_LEN.

Ports:
i_rxc  in  1  RGMII receive clock; sole clock.
i_rst_n  in  1  asynchronous active-low reset.
i_rxd_rise  in  4  RXD sampled on rising edge.
i_rxd_fall  in  4  RXD sampled on falling edge.
i_rx_ctl_rise  in  1  RX_CTL on rising edge (RX_DV).
i_rx_ctl_fall  in  1  RX_CTL on falling edge (RX_DV xor RX_ER).
o_rx_data  out  8  frame byte, destination MAC first.
o_rx_valid  out  1  o_rx_data qualifier, one per byte.
o_rx_end  out  1  one-cycle pulse after the last o_rx_valid of a frame.
o_rx_err  out  1  coincident with o_rx_end; frame had RX_ER, truncation or an FCS issue.
o_speed1000  out  1  1 = 1000 Mb/s byte mode; 0 = 10/100 nibble mode.
o_link_up  out  1  in-band link status.

Behaviour:
- Reset: o_rx_data=0, o_rx_valid=0, o_rx_end=0, o_rx_err=0, o_speed1000=1, o_link_up=0; FSM to IDLE.
- Reset mid-frame drops the frame silently. After release, the FSM waits in IDLE for DV=0 before accepting a new frame.
- DV = i_rx_ctl_rise. ER = i_rx_ctl_rise ^ i_rx_ctl_fall.
- In-band status: sampled in IDLE only, when i_rx_ctl_rise=0 and i_rx_ctl_fall=0.
  - o_link_up <= i_rxd_rise[0].
  - o_speed1000 <= (i_rxd_rise[2:1]==2'b10).
  - Values 00 and 01 select nibble mode; 11 is ignored (hold).
  - Speed and link never change while a frame is in progress.
- Byte formation, 1000 mode: byte = {i_rxd_fall, i_rxd_rise}, one per DV cycle.
- Byte formation, nibble mode: only i_rxd_rise is used. The first DV nibble is the low nibble and a phase bit toggles each DV cycle. A byte is complete on every second DV cycle: byte = {current nibble, held nibble}.
  - Phase clears whenever DV=0.
  - An odd trailing nibble at DV fall is discarded and sets the error flag.
- FSM states IDLE, PREAMBLE, DATA, DROP:
  - IDLE -> PREAMBLE on DV rise.
  - PREAMBLE: count formed bytes.
    - Byte 0xD5 -> DATA.
    - Byte other than 0x55/0xD5, or count reaching PRE_MAX without SFD -> DROP.
    - DV fall -> IDLE with no o_rx_end.
  - DATA: each formed byte gives o_rx_valid=1 with o_rx_data = byte, registered, latency 1 i_rxc from the completing sample. Byte counter increments.
    - DV fall -> o_rx_end=1 for one cycle (after the final valid), then IDLE.
    - Byte count reaching MAX_LEN -> further bytes suppressed, error flag set, -> DROP.
  - DROP: outputs idle. On DV fall, pulse o_rx_end with o_rx_err=1 only if DATA had been entered this frame; otherwise no pulse. Then -> IDLE.
- Error flag: set by ER during PREAMBLE/DATA, truncation, or an odd nibble. Cleared on entry to PREAMBLE. Driven onto o_rx_err with o_rx_end.
- o_rx_valid and o_rx_end are never high in the same cycle.
- Minimum gap: o_rx_end fires at least 1 cycle before the next frame's first o_rx_valid. Back-to-back frames with 1 DV-low cycle are accepted.

Optional Feature:
RX_FCS_STRIP_EN.
- Defined: a 4-byte delay line holds DATA bytes, and only bytes pushed out of the line assert o_rx_valid. The last 4 bytes (FCS) are never forwarded. Frames with fewer than 4 post-SFD bytes produce o_rx_end with o_rx_err=1 and no valid bytes. The delay line flushes on entry to PREAMBLE.
- Undefined: FCS is forwarded as ordinary data; no delay line.

Decomposition:
- Package rgmii_rx_pkg: SFD_BYTE=8'hD5, PRE_BYTE=8'h55, speed codes (2'b00/01/10), FSM state typedef.
- Sub-module rgmii_nibble_pack: DV, rise/fall data and speed in; byte and byte-strobe out, plus the odd-nibble flag.
- FSM, counters and the FCS delay line stay in the top module.

Test Plan:
- 1000 mode: 7x0x55, 0xD5, 64 bytes 0x00..0x3F -> 64 valids with data 0x00..0x3F in order, then one o_rx_end, o_rx_err=0.
- In-band status rxd_rise=4'b0011 in idle -> o_speed1000=0, o_link_up=1. The same frame sent as nibbles (low first) -> identical 64 bytes, one valid every 2 cycles.
- ER asserted (ctl_fall != ctl_rise) on byte 10 of a 1000 mode frame -> all bytes still forwarded, o_rx_end with o_rx_err=1.
- 1600-byte frame -> exactly 1526 valids, then o_rx_end with o_rx_err=1 at DV fall.
- Preamble with 0x12 before SFD -> no valid and no end. A following good frame after 1 idle cycle is received intact.
- With RX_FCS_STRIP_EN: 68-byte frame -> 64 valids, last data byte = frame byte 63. Reset asserted mid-frame -> outputs 0 immediately; the next frame is received correctly.

Source files
------------

// File: rtl/rgmii_rx_pkg.sv
// Shared constants and FSM state type for the RGMII receive frame parser.
// Nothing here changes when RX_FCS_STRIP_EN is defined.
package rgmii_rx_pkg;

   localparam logic [7:0] SFD_BYTE   = 8'hD5;
   localparam logic [7:0] PRE_BYTE   = 8'h55;

   localparam logic [1:0] SPEED_10   = 2'b00;
   localparam logic [1:0] SPEED_100  = 2'b01;
   localparam logic [1:0] SPEED_1000 = 2'b10;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DROP
   } state_t;

endpackage

// File: rtl/rgmii_rx_frame_parser_nibble_pack.sv
// Turns SDR RGMII samples into bytes.
// 1000 mode produces a byte on every DV cycle; 10/100 mode pairs rising-edge nibbles, low nibble first.
module rgmii_nibble_pack (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dv,
   input  logic [3:0] rxd_rise,
   input  logic [3:0] rxd_fall,
   input  logic       speed1000,
   output logic [7:0] byte_data,
   output logic       byte_strobe,
   output logic       odd_nibble
);

   logic       phase;
   logic [3:0] held;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         phase <= 1'b0;
         held  <= 4'h0;
      end else if (!dv || speed1000) begin
         phase <= 1'b0;
      end else begin
         phase <= ~phase;
         if (!phase) held <= rxd_rise;
      end
   end

   // A set phase at DV fall means the frame ended on half a byte.
   always_comb begin
      odd_nibble = !dv && phase;
      if (speed1000) begin
         byte_data   = {rxd_fall, rxd_rise};
         byte_strobe = dv;
      end else begin
         byte_data   = {rxd_rise, held};
         byte_strobe = dv && phase;
      end
   end

endmodule

// File: rtl/rgmii_rx_frame_parser.sv
// RGMII receive frame parser: in-band status decode, preamble/SFD strip, byte-write interface to the RX buffer.
// Define RX_FCS_STRIP_EN to hold back the trailing 4 FCS bytes through a delay line.
module rgmii_rx_frame_parser
   import rgmii_rx_pkg::*;
#(
   parameter int MAX_LEN = 1526,
   parameter int PRE_MAX = 8,
   parameter int LEN_W   = 11
) (
   input  logic       i_rxc,
   input  logic       i_rst_n,
   input  logic [3:0] i_rxd_rise,
   input  logic [3:0] i_rxd_fall,
   input  logic       i_rx_ctl_rise,
   input  logic       i_rx_ctl_fall,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_rx_end,
   output logic       o_rx_err,
   output logic       o_speed1000,
   output logic       o_link_up
);

   localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

   logic             dv, er;
   logic             dv_prev, err_flag, data_seen;
   state_t           state, pre_state;
   logic [LEN_W-1:0] count, pre_base, pre_count;
   logic [7:0]       pk_byte;
   logic             pk_strobe, pk_odd, fcs_short;

   assign dv = i_rx_ctl_rise;
   assign er = i_rx_ctl_rise ^ i_rx_ctl_fall;

   rgmii_nibble_pack u_pack (
      .clk        (i_rxc),
      .rst_n      (i_rst_n),
      .dv         (dv),
      .rxd_rise   (i_rxd_rise),
      .rxd_fall   (i_rxd_fall),
      .speed1000  (o_speed1000),
      .byte_data  (pk_byte),
      .byte_strobe(pk_strobe),
      .odd_nibble (pk_odd)
   );

`ifdef RX_FCS_STRIP_EN
   logic [7:0] fcs_line [4];
   logic [2:0] fcs_fill;
   assign fcs_short = (fcs_fill != 3'd4);
`else
   assign fcs_short = 1'b0;
`endif

   // Preamble step is shared by the DV-rise cycle in IDLE and by PREAMBLE itself.
   always_comb begin
      pre_base  = (state == ST_PREAMBLE) ? count : '0;
      pre_state = ST_PREAMBLE;
      pre_count = pre_base;
      if (pk_strobe) begin
         if (pk_byte == SFD_BYTE) begin
            pre_state = ST_DATA;
            pre_count = '0;
         end else if (pk_byte != PRE_BYTE || pre_base + ONE >= LEN_W'(PRE_MAX)) begin
            pre_state = ST_DROP;
         end else begin
            pre_count = pre_base + ONE;
         end
      end
   end

   always_ff @(posedge i_rxc or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state       <= ST_IDLE;
         dv_prev     <= 1'b1;
         err_flag    <= 1'b0;
         data_seen   <= 1'b0;
         count       <= '0;
         o_rx_data   <= 8'h00;
         o_rx_valid  <= 1'b0;
         o_rx_end    <= 1'b0;
         o_rx_err    <= 1'b0;
         o_speed1000 <= 1'b1;
         o_link_up   <= 1'b0;
`ifdef RX_FCS_STRIP_EN
         fcs_fill    <= 3'd0;
         for (int i = 0; i < 4; i++) fcs_line[i] <= 8'h00;
`endif
      end else begin
         dv_prev    <= dv;
         o_rx_valid <= 1'b0;
         o_rx_end   <= 1'b0;
         o_rx_err   <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (!i_rx_ctl_rise && !i_rx_ctl_fall) begin
                  o_link_up <= i_rxd_rise[0];
                  case (i_rxd_rise[2:1])
                     SPEED_1000:          o_speed1000 <= 1'b1;
                     SPEED_10, SPEED_100: o_speed1000 <= 1'b0;
                     default:             ;
                  endcase
               end
               if (dv && !dv_prev) begin
                  err_flag  <= er;
                  state     <= pre_state;
                  count     <= pre_count;
                  data_seen <= (pre_state == ST_DATA);
`ifdef RX_FCS_STRIP_EN
                  fcs_fill  <= 3'd0;
`endif
               end
            end
            ST_PREAMBLE: begin
               if (!dv) begin
                  state <= ST_IDLE;
               end else begin
                  if (er) err_flag <= 1'b1;
                  state     <= pre_state;
                  count     <= pre_count;
                  data_seen <= (pre_state == ST_DATA);
               end
            end
            ST_DATA: begin
               if (!dv) begin
                  o_rx_end <= 1'b1;
                  o_rx_err <= err_flag | pk_odd | fcs_short;
                  state    <= ST_IDLE;
               end else begin
                  if (er) err_flag <= 1'b1;
                  if (pk_strobe) begin
                     if (count == LEN_W'(MAX_LEN)) begin
                        err_flag <= 1'b1;
                        state    <= ST_DROP;
                     end else begin
                        count <= count + ONE;
`ifdef RX_FCS_STRIP_EN
                        fcs_line[0] <= pk_byte;
                        fcs_line[1] <= fcs_line[0];
                        fcs_line[2] <= fcs_line[1];
                        fcs_line[3] <= fcs_line[2];
                        if (fcs_fill == 3'd4) begin
                           o_rx_valid <= 1'b1;
                           o_rx_data  <= fcs_line[3];
                        end else begin
                           fcs_fill <= fcs_fill + 3'd1;
                        end
`else
                        o_rx_valid <= 1'b1;
                        o_rx_data  <= pk_byte;
`endif
                     end
                  end
               end
            end
            ST_DROP: begin
               if (!dv) begin
                  o_rx_end <= data_seen;
                  o_rx_err <= data_seen;
                  state    <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rgmii_rx_frame_parser.sv
// Self-checking bench for rgmii_rx_frame_parser: table of frame scenarios plus hand-written reset and status sequences.
// Expectations follow RX_FCS_STRIP_EN when the bench is built with that macro.
module tb_rgmii_rx_frame_parser;

`ifdef RX_FCS_STRIP_EN
   localparam int STRIP = 4;
`else
   localparam int STRIP = 0;
`endif
   localparam int MAX_LEN = 1526;

   logic       rxc = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] rxd_rise = 4'h0;
   logic [3:0] rxd_fall = 4'h0;
   logic       ctl_rise = 1'b0;
   logic       ctl_fall = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, rx_end, rx_err, speed1000, link_up;

   rgmii_rx_frame_parser dut (
      .i_rxc        (rxc),
      .i_rst_n      (rst_n),
      .i_rxd_rise   (rxd_rise),
      .i_rxd_fall   (rxd_fall),
      .i_rx_ctl_rise(ctl_rise),
      .i_rx_ctl_fall(ctl_fall),
      .o_rx_data    (rx_data),
      .o_rx_valid   (rx_valid),
      .o_rx_end     (rx_end),
      .o_rx_err     (rx_err),
      .o_speed1000  (speed1000),
      .o_link_up    (link_up)
   );

   always #4 rxc = ~rxc;

   int checks = 0;
   int errors = 0;
   logic [3:0] idle_code = 4'b0101;

   logic [7:0] got [$];
   int end_count, overlap, stray_err, cyc, prev_vcyc, gap_min, gap_max;
   logic last_err;

   // Monitor samples 2 ns after each rising edge, away from both edges.
   always @(posedge rxc) begin
      #2;
      if (rst_n) begin
         cyc++;
         if (rx_valid) begin
            got.push_back(rx_data);
            if (prev_vcyc >= 0) begin
               if (cyc - prev_vcyc < gap_min) gap_min = cyc - prev_vcyc;
               if (cyc - prev_vcyc > gap_max) gap_max = cyc - prev_vcyc;
            end
            prev_vcyc = cyc;
         end
         if (rx_end) begin
            end_count++;
            last_err = rx_err;
         end
         if (rx_valid && rx_end) overlap++;
         if (rx_err && !rx_end) stray_err++;
      end
   end

   task automatic clear_mon();
      got.delete();
      end_count = 0;
      last_err  = 1'b0;
      prev_vcyc = -1;
      gap_min   = 1000000;
      gap_max   = 0;
   endtask

   task automatic check_output(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic dv, input logic er, input logic [3:0] r, input logic [3:0] f);
      @(negedge rxc);
      ctl_rise = dv;
      ctl_fall = dv ^ er;
      rxd_rise = r;
      rxd_fall = f;
   endtask

   task automatic idle(input int n);
      repeat (n) apply_stimulus(1'b0, 1'b0, idle_code, 4'h0);
   endtask

   task automatic send_byte(input logic [7:0] b, input bit mode1000, input logic er);
      if (mode1000) begin
         apply_stimulus(1'b1, er, b[3:0], b[7:4]);
      end else begin
         apply_stimulus(1'b1, er, b[3:0], 4'h0);
         apply_stimulus(1'b1, er, b[7:4], 4'h0);
      end
   endtask

   task automatic send_frame(input bit mode1000, input int len, input int er_idx, input bit bad_pre, input bit odd_nib);
      for (int i = 0; i < 7; i++) send_byte((bad_pre && i == 5) ? 8'h12 : 8'h55, mode1000, 1'b0);
      send_byte(8'hD5, mode1000, 1'b0);
      for (int i = 0; i < len; i++) send_byte(i[7:0], mode1000, i == er_idx);
      if (odd_nib) apply_stimulus(1'b1, 1'b0, 4'hA, 4'h0);
   endtask

   task automatic check_data(input string name, input int per);
      int bad = 0;
      int first = -1;
      logic [7:0] exp;
      for (int k = 0; k < got.size(); k++) begin
         exp = (per > 0) ? 8'((k % per) & 255) : 8'h00;
         if (got[k] !== exp) begin
            bad++;
            if (first < 0) first = k;
         end
      end
      if (bad != 0) $display("[TB] %s first bad byte index %0d", name, first);
      check_output({name, " data errors"}, bad, 0);
   endtask

   function automatic int fwd(input int n);
      int m = (n > MAX_LEN) ? MAX_LEN : n;
      return (m > STRIP) ? m - STRIP : 0;
   endfunction

   typedef struct {
      string name;
      bit    mode1000;
      int    len;
      int    er_idx;
      bit    bad_pre;
      bit    odd_nib;
      bit    lead_bad;
      int    frames;
      int    exp_per;
      int    exp_ends;
      bit    exp_err;
   } vec_t;

   vec_t vecs [10];

   initial begin
      vecs[0] = '{"g1000",      1'b1, 64,   -1, 1'b0, 1'b0, 1'b0, 1, fwd(64),   1, 1'b0};
      vecs[1] = '{"nibble",     1'b0, 64,   -1, 1'b0, 1'b0, 1'b0, 1, fwd(64),   1, 1'b0};
      vecs[2] = '{"er1000",     1'b1, 64,   10, 1'b0, 1'b0, 1'b0, 1, fwd(64),   1, 1'b1};
      vecs[3] = '{"long",       1'b1, 1600, -1, 1'b0, 1'b0, 1'b0, 1, fwd(1600), 1, 1'b1};
      vecs[4] = '{"badpre",     1'b1, 64,   -1, 1'b1, 1'b0, 1'b0, 1, 0,         0, 1'b0};
      vecs[5] = '{"after_bad",  1'b1, 64,   -1, 1'b0, 1'b0, 1'b1, 1, fwd(64),   1, 1'b0};
      vecs[6] = '{"b2b",        1'b1, 64,   -1, 1'b0, 1'b0, 1'b0, 2, fwd(64),   2, 1'b0};
      vecs[7] = '{"odd_nibble", 1'b0, 64,   -1, 1'b0, 1'b1, 1'b0, 1, fwd(64),   1, 1'b1};
      vecs[8] = '{"short",      1'b1, 2,    -1, 1'b0, 1'b0, 1'b0, 1, fwd(2),    1, STRIP > 0};
      vecs[9] = '{"nib_er",     1'b0, 40,    5, 1'b0, 1'b0, 1'b0, 1, fwd(40),   1, 1'b1};

      overlap   = 0;
      stray_err = 0;
      cyc       = 0;
      clear_mon();

      // Reset values, and status inputs ignored while reset is held.
      #20;
      check_output("reset data", rx_data, 0);
      check_output("reset valid", rx_valid, 0);
      check_output("reset end", rx_end, 0);
      check_output("reset err", rx_err, 0);
      check_output("reset speed1000", speed1000, 1);
      check_output("reset link", link_up, 0);
      idle_code = 4'b0011;
      idle(2);
      check_output("reset hold speed1000", speed1000, 1);
      rst_n = 1'b1;

      // In-band status decode.
      idle(2);
      check_output("status 0011 speed", speed1000, 0);
      check_output("status 0011 link", link_up, 1);
      idle_code = 4'b0111;
      idle(2);
      check_output("status 11 hold speed", speed1000, 0);
      idle_code = 4'b0100;
      idle(2);
      check_output("status 0100 speed", speed1000, 1);
      check_output("status 0100 link", link_up, 0);
      idle_code = 4'b0001;
      idle(2);
      check_output("status 0001 speed", speed1000, 0);
      check_output("status 0001 link", link_up, 1);

      for (int v = 0; v < 10; v++) begin
         idle_code = vecs[v].mode1000 ? 4'b0101 : 4'b0011;
         idle(3);
         check_output({vecs[v].name, " speed1000"}, speed1000, vecs[v].mode1000);
         check_output({vecs[v].name, " link"}, link_up, 1);
         clear_mon();
         if (vecs[v].lead_bad) begin
            send_frame(vecs[v].mode1000, 64, -1, 1'b1, 1'b0);
            idle(1);
         end
         for (int f = 0; f < vecs[v].frames; f++) begin
            send_frame(vecs[v].mode1000, vecs[v].len, vecs[v].er_idx, vecs[v].bad_pre, vecs[v].odd_nib);
            idle(1);
         end
         idle(6);
         check_output({vecs[v].name, " valids"}, got.size(), vecs[v].exp_per * vecs[v].frames);
         check_output({vecs[v].name, " ends"}, end_count, vecs[v].exp_ends);
         if (vecs[v].exp_ends > 0) check_output({vecs[v].name, " err"}, last_err, vecs[v].exp_err);
         check_data(vecs[v].name, vecs[v].exp_per);
         if (vecs[v].frames == 1 && got.size() > 1) begin
            check_output({vecs[v].name, " min gap"}, gap_min, vecs[v].mode1000 ? 1 : 2);
            check_output({vecs[v].name, " max gap"}, gap_max, vecs[v].mode1000 ? 1 : 2);
         end
      end

      // Reset in the middle of a frame, released while DV is still high.
      idle_code = 4'b0101;
      idle(3);
      send_frame(1'b1, 10, -1, 1'b0, 1'b0);
      check_output("pre-reset valid", rx_valid, 1);
      rst_n = 1'b0;
      #1;
      check_output("midreset valid", rx_valid, 0);
      check_output("midreset data", rx_data, 0);
      check_output("midreset end", rx_end, 0);
      for (int i = 0; i < 3; i++) send_byte(8'h55, 1'b1, 1'b0);
      rst_n = 1'b1;
      clear_mon();
      send_byte(8'hD5, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) send_byte(i[7:0], 1'b1, 1'b0);
      idle(3);
      check_output("held dv valids", got.size(), 0);
      check_output("held dv ends", end_count, 0);
      check_output("post-reset link", link_up, 1);
      clear_mon();
      send_frame(1'b1, 64, -1, 1'b0, 1'b0);
      idle(6);
      check_output("post-reset valids", got.size(), fwd(64));
      check_output("post-reset ends", end_count, 1);
      check_output("post-reset err", last_err, 0);
      check_data("post-reset", fwd(64));

      check_output("valid/end overlap", overlap, 0);
      check_output("stray err", stray_err, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
